// File: rtl/tx_ctrl_pkg.sv
// Shared types and constants for the TX bring-up sequencer.
package tx_ctrl_pkg;

  localparam int CODE_W       = 6;
  localparam int CODE_MAX_DEF = 40;
  localparam int TMR_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    RAMP_UP,
    PRBS_REL,
    ACTIVE,
    RAMP_DN
  } state_t;

  function automatic logic [CODE_W-1:0] step_up(input logic [CODE_W-1:0] c,
                                                input logic [CODE_W-1:0] t);
    return (c < t) ? c + CODE_W'(1) : c;
  endfunction

  function automatic logic [CODE_W-1:0] step_dn(input logic [CODE_W-1:0] c);
    return (c != '0) ? c - CODE_W'(1) : c;
  endfunction

endpackage

// File: rtl/tx_seq_timer.sv
// Reloadable down-counter; o_done is high while the count sits at zero.
module tx_seq_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/tx_bringup_seq.sv
// TX datapath power-up / power-down sequencer with drive-code ramping
// and error-injection pulse generation.
module tx_bringup_seq
  import tx_ctrl_pkg::*;
#(
  parameter int CODE_MAX  = CODE_MAX_DEF,
  parameter int STEP_WAIT = 16,
  parameter int PRBS_HOLD = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              shutdown,
  input  logic [CODE_W-1:0] tgt_n,
  input  logic [CODE_W-1:0] tgt_p,
  input  logic              err_req,
  output logic [CODE_W-1:0] ctl_buf_n,
  output logic [CODE_W-1:0] ctl_buf_p,
  output logic              rst_mux,
  output logic              rst_prbs,
  output logic              inj_error,
  output logic              busy,
  output logic              ready,
  output logic              cfg_err
);

  localparam logic [CODE_W-1:0] L_MAX   = CODE_W'(CODE_MAX);
  localparam logic [TMR_W-1:0]  L_STEP  = TMR_W'(STEP_WAIT - 1);
  localparam logic [TMR_W-1:0]  L_HOLD  = TMR_W'(PRBS_HOLD);
  localparam logic [TMR_W-1:0]  L_HOLD1 = TMR_W'(PRBS_HOLD - 1);

  state_t            r_state, w_nxt;
  logic [CODE_W-1:0] r_tgt_n, r_tgt_p;
  logic [CODE_W-1:0] r_n, r_p, w_n_nxt, w_p_nxt;
  logic              r_rst_mux, r_rst_prbs, r_inj, r_busy, r_ready, r_cfg_err, r_err_d;
  logic              w_mux_nxt, w_prbs_nxt, w_inj_nxt, w_busy_nxt, w_ready_nxt, w_cfg_nxt;
  logic              w_step, w_load, w_tgt_ok, w_accept;
  logic [TMR_W-1:0]  w_load_val;
  logic [CODE_W-1:0] w_n_up, w_p_up, w_n_dn, w_p_dn;

  assign w_tgt_ok = (tgt_n <= L_MAX) && (tgt_p <= L_MAX);
  assign w_accept = (r_state == IDLE) && start && w_tgt_ok;
  assign w_n_up   = step_up(r_n, r_tgt_n);
  assign w_p_up   = step_up(r_p, r_tgt_p);
  assign w_n_dn   = step_dn(r_n);
  assign w_p_dn   = step_dn(r_p);

  tx_seq_timer #(.W(TMR_W)) u_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tgt_n    <= '0;
      r_tgt_p    <= '0;
      r_n        <= '0;
      r_p        <= '0;
      r_rst_mux  <= 1'b1;
      r_rst_prbs <= 1'b1;
      r_inj      <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_err_d    <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_n        <= w_n_nxt;
      r_p        <= w_p_nxt;
      r_rst_mux  <= w_mux_nxt;
      r_rst_prbs <= w_prbs_nxt;
      r_inj      <= w_inj_nxt;
      r_busy     <= w_busy_nxt;
      r_ready    <= w_ready_nxt;
      r_cfg_err  <= w_cfg_nxt;
      r_err_d    <= err_req;
      if (w_accept) begin
        r_tgt_n <= tgt_n;
        r_tgt_p <= tgt_p;
      end
    end
  end

  // Shutdown while already in RAMP_DN must not reload the step timer,
  // otherwise a held request would stall the ramp-down.
  always_comb begin
    w_nxt      = r_state;
    w_load     = 1'b0;
    w_load_val = L_STEP;
    if (r_state != IDLE && r_state != RAMP_DN && shutdown) begin
      w_nxt  = RAMP_DN;
      w_load = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_nxt      = RST_HOLD;
            w_load     = 1'b1;
            w_load_val = L_HOLD;
          end
        end
        RST_HOLD: begin
          if (w_step) begin
            w_load = 1'b1;
            if (r_tgt_n == '0 && r_tgt_p == '0) begin
              w_nxt      = PRBS_REL;
              w_load_val = L_HOLD1;
            end else begin
              w_nxt = RAMP_UP;
            end
          end
        end
        RAMP_UP: begin
          if (w_step) begin
            w_load = 1'b1;
            if (w_n_up == r_tgt_n && w_p_up == r_tgt_p) begin
              w_nxt      = PRBS_REL;
              w_load_val = L_HOLD1;
            end
          end
        end
        PRBS_REL: begin
          if (w_step) w_nxt = ACTIVE;
        end
        ACTIVE: ;
        RAMP_DN: begin
          if (r_n == '0 && r_p == '0) begin
            w_nxt = IDLE;
          end else if (w_step) begin
            w_load = 1'b1;
            if (w_n_dn == '0 && w_p_dn == '0) w_nxt = IDLE;
          end
        end
        default: w_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_n_nxt = r_n;
    w_p_nxt = r_p;
    if (r_state == RAMP_UP && w_nxt != RAMP_DN && w_step) begin
      w_n_nxt = w_n_up;
      w_p_nxt = w_p_up;
    end else if (r_state == RAMP_DN && w_step) begin
      w_n_nxt = w_n_dn;
      w_p_nxt = w_p_dn;
    end
    case (w_nxt)
      IDLE, RST_HOLD: w_mux_nxt = 1'b1;
      RAMP_DN:        w_mux_nxt = r_rst_mux;
      default:        w_mux_nxt = 1'b0;
    endcase
    w_prbs_nxt  = !(w_nxt == PRBS_REL || w_nxt == ACTIVE);
    w_ready_nxt = (w_nxt == ACTIVE);
    w_busy_nxt  = (w_nxt != IDLE);
    w_inj_nxt   = (r_state == ACTIVE) && (w_nxt == ACTIVE) && err_req && !r_err_d;
    w_cfg_nxt   = r_cfg_err;
    if (r_state == IDLE && start) w_cfg_nxt = !w_tgt_ok;
  end

  assign ctl_buf_n = r_n;
  assign ctl_buf_p = r_p;
  assign rst_mux   = r_rst_mux;
  assign rst_prbs  = r_rst_prbs;
  assign inj_error = r_inj;
  assign busy      = r_busy;
  assign ready     = r_ready;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_tx_bringup_seq.sv
// Randomized bench for tx_bringup_seq: expected output changes are derived
// from the sequencing timeline and matched against observed changes.
module tb_tx_bringup_seq;

  localparam int S   = 4;
  localparam int H   = 8;
  localparam int BIG = 1 << 30;

  typedef struct packed {
    logic [5:0] n;
    logic [5:0] p;
    logic mux, prbs, inj, busy, ready, cfg;
  } ovec_t;

  typedef struct {
    int    t;
    ovec_t v;
  } ev_t;

  logic clk = 1'b0;
  logic rst, start, shutdown, err_req;
  logic [5:0] tgt_n, tgt_p;
  logic [5:0] ctl_buf_n, ctl_buf_p;
  logic rst_mux, rst_prbs, inj_error, busy, ready, cfg_err;

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  ev_t   q[$];
  ovec_t m_vec, prev, cur;
  logic  mon_en = 1'b0;
  logic  mon_init = 1'b0;

  tx_bringup_seq #(.CODE_MAX(40), .STEP_WAIT(S), .PRBS_HOLD(H)) dut (
    .clk(clk), .rst(rst), .start(start), .shutdown(shutdown),
    .tgt_n(tgt_n), .tgt_p(tgt_p), .err_req(err_req),
    .ctl_buf_n(ctl_buf_n), .ctl_buf_p(ctl_buf_p), .rst_mux(rst_mux),
    .rst_prbs(rst_prbs), .inj_error(inj_error), .busy(busy),
    .ready(ready), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ovec_t reset_vec();
    ovec_t v;
    v = '0;
    v.mux = 1'b1;
    v.prbs = 1'b1;
    return v;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Monitor: every observed change of the output vector is one transaction.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {ctl_buf_n, ctl_buf_p, rst_mux, rst_prbs, inj_error, busy, ready, cfg_err};
      while (q.size() > 0 && q[0].t < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_change: edge %0d saw no change, required %h at edge %0d",
                 cyc, q[0].v, q[0].t);
        void'(q.pop_front());
      end
      if (!mon_init) begin
        n_cmp++;
        if (cur !== reset_vec()) begin
          n_bad++;
          $display("FAIL reset_state: got %h, required %h", cur, reset_vec());
        end
        mon_init = 1'b1;
      end else if (cur !== prev) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: edge %0d got %h (was %h), none expected",
                   cyc, cur, prev);
        end else begin
          ev_t e;
          e = q.pop_front();
          if (e.t != cyc || e.v !== cur) begin
            n_bad++;
            $display("FAIL output_change: got %h at edge %0d, required %h at edge %0d",
                     cur, cyc, e.v, e.t);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int t);
    while (cyc < t - 1) tick();
  endtask

  task automatic plan(input int t, input ovec_t v, input int cut);
    ev_t e;
    if (t < cut && v !== m_vec) begin
      e.t = t;
      e.v = v;
      q.push_back(e);
      m_vec = v;
    end
  endtask

  function automatic int ready_time(input int e, input int n, input int p);
    return e + H + 1 + imax(n, p) * S + H;
  endfunction

  task automatic plan_bringup(input int e, input int n, input int p, input int cut);
    ovec_t v;
    int m, t1;
    v = m_vec;
    m = imax(n, p);
    t1 = e + H + 1;
    v.busy = 1'b1;
    v.cfg = 1'b0;
    plan(e, v, cut);
    v.mux = 1'b0;
    if (m == 0) v.prbs = 1'b0;
    plan(t1, v, cut);
    for (int k = 1; k <= m; k++) begin
      v.n = 6'(imin(k, n));
      v.p = 6'(imin(k, p));
      if (k == m) v.prbs = 1'b0;
      plan(t1 + k * S, v, cut);
    end
    v.ready = 1'b1;
    plan(t1 + m * S + H, v, cut);
  endtask

  task automatic plan_shutdown(input int d, output int fin);
    ovec_t v;
    int cn, cp, m;
    v = m_vec;
    v.ready = 1'b0;
    v.prbs = 1'b1;
    v.inj = 1'b0;
    plan(d, v, BIG);
    cn = int'(v.n);
    cp = int'(v.p);
    m = imax(cn, cp);
    if (m == 0) begin
      v.mux = 1'b1;
      v.busy = 1'b0;
      plan(d + 1, v, BIG);
      fin = d + 1;
    end else begin
      for (int k = 1; k <= m; k++) begin
        v.n = 6'(imax(cn - k, 0));
        v.p = 6'(imax(cp - k, 0));
        if (k == m) begin
          v.mux = 1'b1;
          v.busy = 1'b0;
        end
        plan(d + k * S, v, BIG);
      end
      fin = d + m * S;
    end
  endtask

  task automatic bad_start(input int n, input int p);
    ovec_t v;
    tick();
    v = m_vec;
    v.cfg = 1'b1;
    plan(cyc + 1, v, BIG);
    tgt_n = 6'(n);
    tgt_p = 6'(p);
    start = 1'b1;
    tick();
    start = 1'b0;
    shutdown = 1'b1;
    tick();
    shutdown = 1'b0;
    repeat (2) tick();
  endtask

  // mode 0: full bring-up, error pulses, shutdown from ACTIVE
  // mode 1: shutdown at cycle e+off;  mode 2: reset at cycle e+off
  task automatic run_iter(input int n, input int p, input int mode, input int off, input int h0);
    int e, r, d, fin, h, l;
    ovec_t v;
    tick();
    e = cyc + 1;
    r = ready_time(e, n, p);
    if (mode != 0 && off == 0) off = $urandom_range(1, r - e - 1);
    tgt_n = 6'(n);
    tgt_p = 6'(p);
    start = 1'b1;
    plan_bringup(e, n, p, (mode == 0) ? BIG : e + off);
    tick();
    start = 1'b0;
    tgt_n = 6'($urandom_range(0, 40));
    tgt_p = 6'($urandom_range(0, 40));
    if (mode == 0) begin
      if (imax(n, p) > 0) begin
        go_to(e + H + 3);
        err_req = 1'b1;
        start = 1'b1;
        tgt_n = 6'd40;
        tgt_p = 6'd40;
        tick();
        start = 1'b0;
        repeat (4) tick();
        err_req = 1'b0;
      end
      go_to(r + 1);
      for (int j = 0; j < 3; j++) begin
        h = (j == 0) ? h0 : $urandom_range(1, 5);
        l = $urandom_range(1, 3);
        v = m_vec;
        v.inj = 1'b1;
        plan(cyc + 1, v, BIG);
        v.inj = 1'b0;
        plan(cyc + 2, v, BIG);
        err_req = 1'b1;
        repeat (h) tick();
        err_req = 1'b0;
        repeat (l) tick();
      end
      d = cyc + 1;
    end else begin
      d = e + off;
      go_to(d);
    end
    if (mode == 2) begin
      plan(d, reset_vec(), BIG);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (2) tick();
    end else begin
      plan_shutdown(d, fin);
      shutdown = 1'b1;
      tick();
      shutdown = 1'b0;
      go_to(fin + 2);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    shutdown = 1'b0;
    err_req = 1'b0;
    tgt_n = '0;
    tgt_p = '0;
    repeat (3) tick();
    rst = 1'b0;
    m_vec = reset_vec();
    mon_en = 1'b1;
    repeat (2) tick();

    bad_start(41, 1);
    run_iter(3, 1, 0, 0, 5);
    run_iter(0, 0, 0, 0, 2);
    run_iter(3, 1, 2, 19, 1);
    bad_start(5, 50);
    run_iter(2, 4, 1, 14, 1);
    run_iter(40, 37, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) bad_start($urandom_range(41, 63), $urandom_range(0, 63));
      run_iter($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 2), 0,
               $urandom_range(1, 5));
    end
    repeat (5) tick();

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: %0d expected changes never seen, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_bringup_seq.md
# tx_bringup_seq

Power-up and power-down sequencer for the transmit datapath. It owns the TX mux reset, the PRBS reset and the output-buffer drive-strength codes (6-bit `CTL_BUF_N`/`CTL_BUF_P`, legal range 0–40).
- Bring-up: releases the mux reset, ramps drive strength one code at a time to the programmed targets, releases the PRBS generators, then signals ready.
- Shutdown: runs the reverse sequence.
- While active, it also converts error-injection requests into single-cycle `inj_error` pulses.

## Interface
Parameters:
- `CODE_MAX`, 40: highest legal drive code.
- `STEP_WAIT`, 16: cycles between drive-code steps (≥1).
- `PRBS_HOLD`, 32: cycles of mux-reset hold before the ramp, and cycles of PRBS settle before ready (≥1).

Ports:
- `clk`  in  1: sequencer clock. Single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: bring-up request. Sampled only in IDLE.
- `shutdown`  in  1: power-down request. Sampled in every state except IDLE.
- `tgt_n`  in  6: target N drive code. Captured on an accepted `start`.
- `tgt_p`  in  6: target P drive code. Captured on an accepted `start`.
- `err_req`  in  1: error-injection request. Rising-edge detected.
- `ctl_buf_n`  out  6: N drive code to the buffer decoder.
- `ctl_buf_p`  out  6: P drive code to the buffer decoder.
- `rst_mux`  out  1: reset to the 16:4 and 4:1 muxes and the clock divider.
- `rst_prbs`  out  1: reset to the PRBS generators.
- `inj_error`  out  1: one-cycle error-injection pulse.
- `busy`  out  1: high whenever state ≠ IDLE.
- `ready`  out  1: high only in ACTIVE.
- `cfg_err`  out  1: target out of range. Sticky.

## Operation
Reset values (all outputs registered):
- `ctl_buf_n`=0, `ctl_buf_p`=0.
- `rst_mux`=1, `rst_prbs`=1.
- `inj_error`=0, `busy`=0, `ready`=0, `cfg_err`=0.
- State = IDLE.

States:
- **IDLE**
  - `start`=1 with `tgt_n`≤`CODE_MAX` and `tgt_p`≤`CODE_MAX`: capture targets, clear `cfg_err`, go to RST_HOLD.
  - `start`=1 with either target >`CODE_MAX`: set `cfg_err`, stay in IDLE.
  - `shutdown` is ignored in IDLE.
- **RST_HOLD**: hold for `PRBS_HOLD` cycles. On exit, clear `rst_mux`.
  - If both targets are 0, go directly to PRBS_REL.
  - Otherwise go to RAMP_UP.
- **RAMP_UP**
  - Step timer loads `STEP_WAIT`-1 on entry and reloads after every step. A step occurs when the timer reaches 0.
  - On each step, each code below its target increments by 1, independently of the other code.
  - The step edge that makes both codes equal their targets also enters PRBS_REL.
- **PRBS_REL**: clear `rst_prbs` on entry. After `PRBS_HOLD` cycles, go to ACTIVE and set `ready`.
- **ACTIVE**
  - Each rising edge of `err_req` produces `inj_error`=1 for exactly the next cycle.
  - `err_req` is ignored in all other states.
- **RAMP_DN**
  - On entry: set `rst_prbs`=1 and `ready`=0.
  - Every `STEP_WAIT` cycles, each nonzero code decrements by 1.
  - The edge where both codes reach 0 sets `rst_mux`=1, clears `busy` and enters IDLE. If both codes are already 0 on entry, this happens on the next edge.

Boundary rules:
- `shutdown` in any non-IDLE state enters RAMP_DN on the next edge. It has priority over all other transitions.
- `start` outside IDLE is ignored. Targets cannot change mid-sequence.
- Codes never exceed their captured targets and never go below 0.
- `rst` in any state restores all reset values on the next edge. Codes drop to 0 immediately; no ramp-down is performed.

## Timing
- All outputs change only on `clk` rising edges. No combinational input-to-output paths.
- Reference timeline: `start` accepted at edge E.
  - E: enter RST_HOLD.
  - E+`PRBS_HOLD`+1: `rst_mux` falls.
  - First code step at E+`PRBS_HOLD`+1+`STEP_WAIT`, then one step every `STEP_WAIT` cycles.
  - `rst_prbs` falls on the final step edge F.
  - `ready` rises at F+`PRBS_HOLD`.
- `inj_error` asserts one cycle after the `err_req` rising edge. There is no pulse for a held-high `err_req`.

## Structure
- Package `tx_ctrl_pkg`:
  - state enum (IDLE, RST_HOLD, RAMP_UP, PRBS_REL, ACTIVE, RAMP_DN);
  - `CODE_W`=6;
  - `CODE_MAX_DEF`=40.
- Sub-module `tx_seq_timer`: reloadable down-counter with a `done` flag. Shared between the hold phases and the step pacing.

## Test plan
Default bench parameters: `STEP_WAIT`=4, `PRBS_HOLD`=8.
- **Bring-up**: `tgt_n`=3, `tgt_p`=1, `start` at edge 0.
  - `rst_mux` falls at edge 9.
  - Codes (n/p): 1/1 at edge 13, 2/1 at edge 17, 3/1 at edge 21.
  - `rst_prbs` falls at edge 21; `ready` rises at edge 29.
- **Out-of-range target**: `tgt_n`=41 with `start` → `cfg_err`=1, `busy` stays 0, codes stay 0. A following valid `start` clears `cfg_err`.
- **Error injection**: in ACTIVE, `err_req` held high for 5 cycles → exactly one `inj_error` cycle. The same request in RAMP_UP → no pulse.
- **Shutdown from ACTIVE at 3/1**:
  - `ready`=0 and `rst_prbs`=1 on the next edge.
  - Codes 2/0, 1/0, 0/0 at 4-cycle intervals.
  - `rst_mux`=1 and IDLE on the 0/0 edge.
- **Zero targets**: `tgt_n`=`tgt_p`=0 → `rst_mux` and `rst_prbs` both fall at edge 9; `ready` rises at edge 17.
- **Reset mid-ramp**: `rst` at code 2/1 → next edge shows all reset values, with codes at 0/0 and no ramp.
